// File: rtl/spi_sync.sv
// SYNC-stage synchroniser with a selectable reset level.
// Latency is SYNC cycles. It has no backpressure and samples din on every cycle.
module spi_sync #(
    parameter int SYNC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic init,
    input  logic din,
    output logic dout
);

    logic [SYNC-1:0] stg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stg <= {SYNC{init}};
        end else begin
            stg <= {stg[SYNC-2:0], din};
        end
    end

    assign dout = stg[SYNC-1];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI target with a one-byte tx buffer. q/rx update one cycle after a detected ck rise.
// It has no backpressure: an empty buffer at reload sends 8'hFF and sets the sticky und flag.
module spi_slave #(
    parameter int SYNC = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       ck,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] d,
    input  logic       load,
    output logic [7:0] q,
    output logic       rx,
    output logic       busy,
    output logic       empty,
    output logic       und
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state, state_nxt;
    logic       cs_s, ck_s, mosi_s, cs_d, ck_d;
    logic       cs_fall, cs_rise, ck_rise, ck_fall;
    logic       shift_rx, shift_tx, reload, consume;
    logic [2:0] cnt;
    logic [7:0] tx_sr, rx_sr, tx_buf;

    spi_sync #(.SYNC(SYNC)) u_sync_cs   (.clock(clock), .reset(reset), .init(1'b1), .din(cs),   .dout(cs_s));
    spi_sync #(.SYNC(SYNC)) u_sync_ck   (.clock(clock), .reset(reset), .init(1'b0), .din(ck),   .dout(ck_s));
    spi_sync #(.SYNC(SYNC)) u_sync_mosi (.clock(clock), .reset(reset), .init(1'b1), .din(mosi), .dout(mosi_s));

    always_comb begin
        cs_fall   = cs_d & ~cs_s;
        cs_rise   = ~cs_d & cs_s;
        ck_rise   = ~ck_d & ck_s;
        ck_fall   = ck_d & ~ck_s;
        state_nxt = state;
        shift_rx  = 1'b0;
        shift_tx  = 1'b0;
        reload    = 1'b0;
        miso      = 1'b1;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = ACTIVE;
                    reload    = 1'b1;
                end
            end
            ACTIVE: begin
                busy = 1'b1;
                miso = tx_sr[7];
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else begin
                    shift_rx = ck_rise;
                    // A falling edge at count 0 opens the next byte, so reload instead of shifting.
                    if (ck_fall) begin
                        if (cnt == 3'd0) reload   = 1'b1;
                        else             shift_tx = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        consume = reload & ~empty;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cs_d   <= 1'b1;
            ck_d   <= 1'b0;
            cnt    <= 3'd0;
            tx_sr  <= 8'hFF;
            rx_sr  <= 8'hFF;
            tx_buf <= 8'h00;
            q      <= 8'h00;
            rx     <= 1'b0;
            empty  <= 1'b1;
            und    <= 1'b0;
        end else begin
            state <= state_nxt;
            cs_d  <= cs_s;
            ck_d  <= ck_s;
            rx    <= 1'b0;

            if (state == IDLE || cs_rise) begin
                cnt <= 3'd0;
            end else if (shift_rx) begin
                cnt <= cnt + 3'd1;
            end

            if (shift_rx) begin
                rx_sr <= {rx_sr[6:0], mosi_s};
                if (cnt == 3'd7) begin
                    q  <= {rx_sr[6:0], mosi_s};
                    rx <= 1'b1;
                end
            end

            if (reload) begin
                tx_sr <= empty ? 8'hFF : tx_buf;
                if (empty) und <= 1'b1;
            end else if (shift_tx) begin
                tx_sr <= {tx_sr[6:0], 1'b1};
            end

            // A same-cycle load wins: the new byte stays buffered while the old one moves to tx_sr.
            if (load) begin
                tx_buf <= d;
                empty  <= 1'b0;
            end else if (consume) begin
                empty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: single-byte vector table plus multi-byte, underrun, abort and reset sequences.
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int PH   = 6;

    logic       clock, reset, cs, ck, mosi, miso, load, rx, busy, empty, und;
    logic [7:0] d, q;

    int         tests  = 0;
    int         failed = 0;
    int         rx_cnt = 0;
    logic [7:0] q_hist [0:63];

    spi_slave #(.SYNC(SYNC)) dut (
        .clock(clock), .reset(reset), .cs(cs), .ck(ck), .mosi(mosi), .miso(miso),
        .d(d), .load(load), .q(q), .rx(rx), .busy(busy), .empty(empty), .und(und)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx === 1'b1) begin
            q_hist[rx_cnt & 63] = q;
            rx_cnt = rx_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mo;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic do_load(input logic [7:0] v);
        d    = v;
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    // mode 0: normal bit; 1: pulse load in the falling-edge reload cycle; 2: return with ck high
    task automatic xbit(input logic mo, input int mode, input logic [7:0] nd, output logic mi);
        mosi = mo;
        tick(PH);
        mi = miso;
        ck = 1'b1;
        tick(PH);
        if (mode != 2) begin
            ck = 1'b0;
            if (mode == 1) begin
                tick(SYNC);
                d    = nd;
                load = 1'b1;
                tick(1);
                load = 1'b0;
                tick(PH - SYNC - 1);
            end
        end
    endtask

    task automatic xfer(input logic [7:0] mo, input int mode, input logic [7:0] nd, output logic [7:0] mi);
        logic b;
        mi = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            xbit(mo[i], (i == 0) ? mode : 0, nd, b);
            mi[i] = b;
        end
    endtask

    initial begin
        vec_t       vecs [5];
        logic [7:0] mi, mi2, mi3;
        logic       b;
        int         base;

        vecs[0] = '{tx: 8'hA5, mo: 8'h3C};
        vecs[1] = '{tx: 8'h00, mo: 8'hFF};
        vecs[2] = '{tx: 8'hFF, mo: 8'h00};
        vecs[3] = '{tx: 8'h5A, mo: 8'h81};
        vecs[4] = '{tx: 8'h69, mo: 8'h96};

        reset = 1'b1; cs = 1'b1; ck = 1'b0; mosi = 1'b1; d = 8'h00; load = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(1);
        check("rst_q", q, 8'h00);
        check("rst_rx", rx, 1'b0);
        check("rst_miso", miso, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_und", und, 1'b0);

        // Two back-to-back bytes, second loaded after the first has started.
        base = rx_cnt;
        do_load(8'h12);
        check("b2b_empty_loaded", empty, 1'b0);
        cs = 1'b0;
        tick(PH);
        check("b2b_busy", busy, 1'b1);
        check("b2b_empty_consumed", empty, 1'b1);
        do_load(8'h34);
        xfer(8'hC3, 0, 8'h00, mi);
        check("b2b_miso0", mi, 8'h12);
        xfer(8'h81, 2, 8'h00, mi);
        check("b2b_miso1", mi, 8'h34);
        check("b2b_und", und, 1'b0);
        check("b2b_rx_cnt", rx_cnt - base, 2);
        check("b2b_q0", q_hist[base & 63], 8'hC3);
        check("b2b_q1", q_hist[(base + 1) & 63], 8'h81);
        check("b2b_q", q, 8'h81);
        ck = 1'b0;
        tick(PH);
        cs = 1'b1;
        tick(PH);

        for (int i = 0; i < 5; i++) begin
            base = rx_cnt;
            do_load(vecs[i].tx);
            cs = 1'b0;
            tick(PH);
            check($sformatf("vec%0d_empty", i), empty, 1'b1);
            xfer(vecs[i].mo, 0, 8'h00, mi);
            tick(PH);
            check($sformatf("vec%0d_miso", i), mi, vecs[i].tx);
            check($sformatf("vec%0d_q", i), q, vecs[i].mo);
            check($sformatf("vec%0d_rx_cnt", i), rx_cnt - base, 1);
            cs = 1'b1;
            tick(PH);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // Underrun: no byte buffered at cs fall.
        do_reset();
        cs = 1'b0;
        tick(PH);
        check("und_set", und, 1'b1);
        xfer(8'h5E, 0, 8'h00, mi);
        check("und_miso", mi, 8'hFF);
        tick(PH);
        cs = 1'b1;
        tick(PH);
        check("und_sticky", und, 1'b1);
        check("und_q", q, 8'h5E);

        // Abort after five bits, then a clean transfer.
        base = rx_cnt;
        cs = 1'b0;
        tick(PH);
        do_load(8'hC9);
        for (int i = 0; i < 5; i++) xbit(1'b0, 0, 8'h00, b);
        tick(PH);
        cs = 1'b1;
        tick(PH);
        check("abort_rx_cnt", rx_cnt - base, 0);
        check("abort_q", q, 8'h5E);
        check("abort_empty", empty, 1'b0);
        cs = 1'b0;
        tick(PH);
        xfer(8'hA7, 0, 8'h00, mi);
        tick(PH);
        check("abort_next_miso", mi, 8'hC9);
        check("abort_next_q", q, 8'hA7);
        check("abort_next_rx_cnt", rx_cnt - base, 1);
        cs = 1'b1;
        tick(PH);

        // Load lands in the exact reload cycle.
        do_load(8'hF0);
        cs = 1'b0;
        tick(PH);
        do_load(8'h96);
        xfer(8'h11, 1, 8'h3A, mi);
        check("ldrl_miso0", mi, 8'hF0);
        check("ldrl_empty", empty, 1'b0);
        xfer(8'h22, 0, 8'h00, mi2);
        check("ldrl_miso1", mi2, 8'h96);
        xfer(8'h33, 0, 8'h00, mi3);
        check("ldrl_miso2", mi3, 8'h3A);
        tick(PH);
        check("ldrl_q", q, 8'h33);
        cs = 1'b1;
        tick(PH);

        // Reset mid-byte.
        base = rx_cnt;
        do_load(8'h44);
        cs = 1'b0;
        tick(PH);
        for (int i = 0; i < 3; i++) xbit(1'b1, 0, 8'h00, b);
        reset = 1'b1;
        tick(1);
        check("mrst_q", q, 8'h00);
        check("mrst_rx", rx, 1'b0);
        check("mrst_miso", miso, 1'b1);
        check("mrst_busy", busy, 1'b0);
        check("mrst_empty", empty, 1'b1);
        check("mrst_und", und, 1'b0);
        cs = 1'b1;
        tick(PH);
        reset = 1'b0;
        tick(PH);
        check("mrst_rx_cnt", rx_cnt - base, 0);
        check("mrst_busy_after", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC, default 2, giving the number of synchroniser flops on cs, ck and mosi; legal values 2..3.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clock: input, 1 bit, system clock; every register SHALL update on its rising edge.
REQ-004 Port reset: input, 1 bit, synchronous active-high reset.
REQ-005 Port cs: input, 1 bit, SPI chip select from the initiator, active-low, asynchronous to clock.
REQ-006 Port ck: input, 1 bit, SPI clock from the initiator, mode 0 (idle low), asynchronous to clock.
REQ-007 Port mosi: input, 1 bit, serial data in, MSB first.
REQ-008 Port miso: output, 1 bit, serial data out, MSB first.
REQ-009 Port d: input, 8 bits, transmit byte written into the tx buffer.
REQ-010 Port load: input, 1 bit, single-cycle strobe that writes d into the tx buffer.
REQ-011 Port q: output, 8 bits, last complete received byte.
REQ-012 Port rx: output, 1 bit, single-cycle strobe marking q as newly updated.
REQ-013 Port busy: output, 1 bit, high while the synchronised cs is low.
REQ-014 Port empty: output, 1 bit, high when the tx buffer holds no unsent byte.
REQ-015 Port und: output, 1 bit, sticky tx underrun flag.

Function
REQ-016 cs, ck and mosi SHALL each pass through SYNC flops; edges SHALL be detected on the synchronised values only.
REQ-017 Correct operation SHALL require each ck high and low phase to last at least SYNC+1 clock cycles.
REQ-018 The block SHALL have two states: IDLE (synchronised cs high) and ACTIVE (synchronised cs low).
REQ-019 In IDLE, miso SHALL be 1 and the 3-bit bit counter SHALL be 0.
REQ-020 On the cs falling edge, the block SHALL load the tx shift register from the tx buffer if the buffer is full, else with 8'hFF, and set und when the buffer is empty.
REQ-021 On every ck rising edge in ACTIVE, the block SHALL shift the synchronised mosi into the rx shift register LSB and increment the counter modulo 8.
REQ-022 On the rising edge where the counter wraps 7->0, the block SHALL set q to the complete byte and pulse rx high for exactly one cycle, one cycle after the edge is detected.
REQ-023 On a ck falling edge with counter != 0, the block SHALL shift the tx shift register left by one bit.
REQ-024 On a ck falling edge with counter == 0, the block SHALL reload the tx shift register from the tx buffer, or with 8'hFF plus und set, giving back-to-back bytes.
REQ-025 In ACTIVE, miso SHALL equal the tx shift register bit 7 and SHALL change only after a detected ck falling edge or the cs falling edge.
REQ-026 A tx-register reload SHALL consume the buffer (empty set to 1).
REQ-027 load SHALL write d to the buffer and clear empty on the next cycle.
REQ-028 A load on a full buffer SHALL overwrite the buffered byte.
REQ-029 A load in the same cycle as a consume SHALL leave the new d in the buffer with empty at 0, while the old byte goes to the tx register.
REQ-030 A cs rising edge mid-byte SHALL abort: counter to 0, no rx pulse, partial rx bits discarded, q unchanged, tx buffer contents and empty unchanged.
REQ-031 und SHALL clear only on reset.

Reset
REQ-032 Reset SHALL force the following: q=8'h00, rx=0, miso=1, busy=0, empty=1, und=0, counter=0, both shift registers=8'hFF, state IDLE, and all synchroniser flops to idle levels (cs=1, ck=0, mosi=1).
REQ-033 Reset asserted mid-byte SHALL take priority over all other events in the same cycle.

Structure
REQ-034 No shared package SHALL be used; SYNC is the only constant and is local.
REQ-035 One sub-module, spi_sync (a parameterised SYNC-stage synchroniser with reset value input), SHALL be instantiated once per input.

Verification
REQ-036 Load 8'hA5, then drop cs and clock 8 bits with mosi=8'h3C -> miso bits 1,0,1,0,0,1,0,1; q=8'h3C; exactly one rx pulse; empty=1 after the first edge.
REQ-037 Load 8'h12, then 8'h34 after the first byte starts; clock 16 bits with mosi=8'hC3,8'h81 -> miso carries 12 then 34 with no gap; rx pulses twice with q=C3 then 81; und=0.
REQ-038 Drop cs with the buffer empty -> miso all 1s for 8 bits; und=1 and stays 1 after cs rises.
REQ-039 Raise cs after 5 ck cycles -> no rx pulse, q holds its prior value, and the next full transfer receives correctly.
REQ-040 Assert load in the exact cycle of the 8th falling-edge reload -> old byte transmitted, new byte buffered, empty=0.
REQ-041 Assert reset after 3 bits -> all outputs at reset values next cycle, with no rx pulse.
